// File: rtl/hazard_unit_mc_if.sv
// Bundle of the signals exchanged between the pipeline datapath and the
// hazard/forwarding controller. The datapath is the master: it reports stage
// register addresses and controls. The hazard unit is the slave: it returns
// stalls, flushes and forwarding selects.
// mc_state is a debug view of the multi-cycle FSM: 00 idle, 01 busy, 10 done.
interface hazard_unit_mc_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic [1:0]        ex_result_src;
    logic [1:0]        mem_result_src;
    logic              ex_reg_write;
    logic              mem_reg_write;
    logic              wb_reg_write;
    logic              ex_pc_src;
    logic              ex_mc_start;
    logic              stall_if;
    logic              stall_id;
    logic              stall_ex;
    logic              flush_id;
    logic              flush_ex;
    logic              flush_mem;
    logic [1:0]        forward_a_ex;
    logic [1:0]        forward_b_ex;
    logic              mc_busy;
    logic              mc_done;
    logic [1:0]        mc_state;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
               ex_result_src, mem_result_src, ex_reg_write, mem_reg_write,
               wb_reg_write, ex_pc_src, ex_mc_start,
        input  stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem,
               forward_a_ex, forward_b_ex, mc_busy, mc_done, mc_state
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
               ex_result_src, mem_result_src, ex_reg_write, mem_reg_write,
               wb_reg_write, ex_pc_src, ex_mc_start,
        output stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem,
               forward_a_ex, forward_b_ex, mc_busy, mc_done, mc_state
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard and forwarding controller for the 5-stage pipeline with a
// multi-cycle EX stall sequencer (MUL/DIV).
// Optional feature macro: HAZARD_PERF_CNT_EN adds the saturating
// stall_cycles / flush_events counters.
// There are no valid/ready handshakes here: every bus input is a level that
// describes the current cycle's pipeline contents, and every output is a
// level consumed by the stage registers in the same cycle.
module hazard_unit_mc #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_unit_mc_if.slave  bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mc_state_t;

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MC_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

    mc_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mc_stall_raw;
    logic             mc_stall;
    logic             mc_done_c;
    logic             load_stall;

    // MEM beats WB; register x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] mem_rd,
        input logic              mem_we,
        input logic [1:0]        mem_src,
        input logic [REG_AW-1:0] wb_rd,
        input logic              wb_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_we && src != '0 && src == mem_rd) begin
            sel = (mem_src == 2'b11) ? 2'b11 : 2'b10;
        end else if (wb_we && src != '0 && src == wb_rd) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Operand forwarding selects, never masked by stalls.
    always_comb begin
        bus.forward_a_ex = fwd_sel(bus.ex_rs1, bus.mem_rd, bus.mem_reg_write,
                                   bus.mem_result_src, bus.wb_rd, bus.wb_reg_write);
        bus.forward_b_ex = fwd_sel(bus.ex_rs2, bus.mem_rd, bus.mem_reg_write,
                                   bus.mem_result_src, bus.wb_rd, bus.wb_reg_write);
    end

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_stall = (bus.ex_result_src == 2'b01) && bus.ex_reg_write &&
                     (bus.ex_rd != '0) &&
                     ((bus.id_rs1 == bus.ex_rd) || (bus.id_rs2 == bus.ex_rd));
    end

    // Multi-cycle sequencer state and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: the start cycle itself is the first stalled cycle, so the
    // counter is loaded with MC_LAT-1 and BUSY runs down to 1.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        mc_stall_raw = 1'b0;
        mc_done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ex_mc_start) begin
                    mc_stall_raw = 1'b1;
                    cnt_nxt      = LAT_M1;
                    state_nxt    = (MC_LAT > 1) ? BUSY : DONE;
                end
            end
            BUSY: begin
                mc_stall_raw = 1'b1;
                if (cnt == CNT_1) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_1;
                end
            end
            DONE: begin
                mc_done_c = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A start request held through reset must not raise a stall while the
    // FSM is forced idle.
    assign mc_stall = mc_stall_raw & rst_n;

    // Stage control with priority: multi-cycle stall, then branch, then load-use.
    always_comb begin
        bus.stall_if  = load_stall;
        bus.stall_id  = load_stall;
        bus.stall_ex  = 1'b0;
        bus.flush_id  = bus.ex_pc_src;
        bus.flush_ex  = load_stall | bus.ex_pc_src;
        bus.flush_mem = 1'b0;
        if (mc_stall) begin
            bus.stall_if  = 1'b1;
            bus.stall_id  = 1'b1;
            bus.stall_ex  = 1'b1;
            bus.flush_id  = 1'b0;
            bus.flush_ex  = 1'b0;
            bus.flush_mem = 1'b1;
        end
        bus.mc_busy  = mc_stall;
        bus.mc_done  = mc_done_c;
        bus.mc_state = state;
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters for stalled fetch cycles and ID flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (bus.stall_if && stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (bus.flush_id && flush_events != 32'hFFFF_FFFF) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline. It resolves EX-stage operand forwarding from MEM and WB, load-use stalls, and taken-branch/jump flushes. It also adds a sequential stall controller for multi-cycle EX operations (MUL/DIV), which freezes IF/ID/EX and injects MEM bubbles for a programmable latency. It sits beside the datapath and drives the stage-register enables/clears and the EX operand muxes.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- MC_LAT, 4, stall cycles per multi-cycle op (legal 1..255).
- CNT_W, 8, internal latency-counter width (must hold MC_LAT).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; one clock, reset asynchronous active-low.
- id_rs1, id_rs2  in  REG_AW  source registers in ID.
- ex_rs1, ex_rs2, ex_rd  in  REG_AW  sources/destination in EX.
- mem_rd, wb_rd  in  REG_AW  destinations in MEM/WB.
- ex_result_src, mem_result_src  in  2  result select (01 = load, 11 = PC+4/imm).
- ex_reg_write, mem_reg_write, wb_reg_write  in  1  write enables.
- ex_pc_src  in  1  taken branch/jump resolved in EX.
- ex_mc_start  in  1  multi-cycle op occupies EX.
- stall_if, stall_id, stall_ex  out  1  hold PC / IF-ID / ID-EX registers.
- flush_id, flush_ex, flush_mem  out  1  clear IF-ID / ID-EX / EX-MEM.
- forward_a_ex, forward_b_ex  out  2  00 regfile, 01 WB, 10 MEM ALU, 11 MEM result_src=11.
- mc_busy  out  1  multi-cycle stall active.
- mc_done  out  1  one-cycle pulse, multi-cycle op released.

## Operation
- Forwarding (per operand, combinational): MEM match wins over WB. A match requires equal addresses, the stage's reg_write = 1, and the source != 0. On a MEM match, the code is 11 if mem_result_src == 11, else 10.
- Load-use: load_stall = ex_result_src == 01 & ex_reg_write & ex_rd != 0 & (id_rs1 == ex_rd | id_rs2 == ex_rd).
- MC FSM states: IDLE, BUSY, DONE; counter cnt.
  - IDLE & ex_mc_start: mc_stall = 1. Load cnt <= MC_LAT-1. Go to BUSY if MC_LAT > 1, else go to DONE.
  - BUSY: mc_stall = 1. If cnt == 1 go to DONE; else cnt <= cnt-1.
  - DONE: mc_stall = 0, mc_done = 1. Return to IDLE unconditionally. ex_mc_start is ignored in DONE (it is the same op leaving EX).
- mc_busy = mc_stall.
- Output priority: mc_stall > ex_pc_src > load_stall.
  - mc_stall: stall_if = stall_id = stall_ex = 1, flush_mem = 1, flush_id = flush_ex = 0. ex_pc_src and load_stall are masked.
  - Otherwise:
    - stall_if = stall_id = load_stall.
    - stall_ex = 0, flush_mem = 0.
    - flush_id = ex_pc_src.
    - flush_ex = load_stall | ex_pc_src.
- Forwarding outputs are never masked. While stalled, forwarding still tracks WB, so the held op sees retiring results.

## Timing
- Forwarding, load-use and flush outputs are purely combinational, with zero latency.
- A multi-cycle op sees exactly MC_LAT stalled cycles, then one DONE cycle. It advances out of EX on the DONE cycle's edge, for MC_LAT+1 cycles of EX occupancy in total.
- Back-to-back multi-cycle ops: a new ex_mc_start in the IDLE cycle right after DONE starts a fresh sequence with no gap.
- Reset, at assertion and held: FSM = IDLE, cnt = 0, mc_busy = 0, mc_done = 0. Perf counters = 0.
- The combinational outputs follow their inputs; with all inputs 0, every output is 0.
- Reset asserted mid-BUSY aborts immediately; the stalls drop asynchronously with the FSM.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs stall_cycles [31:0] and flush_events [31:0].
  - stall_cycles increments on every clock with stall_if = 1.
  - flush_events increments on every clock with flush_id = 1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent and the logic is otherwise identical.

## Test plan
- ex_rs1 = 5, mem_rd = 5, mem_reg_write = 1, mem_result_src = 00, wb_rd = 5, wb_reg_write = 1 -> forward_a_ex = 10. Set mem_result_src = 11 -> 11. Set ex_rs1 = 0 -> 00.
- ex_result_src = 01, ex_reg_write = 1, ex_rd = 7, id_rs2 = 7 -> stall_if = stall_id = flush_ex = 1, flush_id = 0. Set ex_rd = 0 -> all 0.
- MC_LAT = 4, ex_mc_start held high -> mc_busy = 1 for exactly 4 cycles, then mc_done = 1 for 1 cycle with stalls low, then IDLE.
- MC_LAT = 4, ex_pc_src = 1 and load_stall conditions during BUSY -> flush_id = flush_ex = 0 and flush_mem = 1. After DONE, with ex_pc_src = 1, flush_id = flush_ex = 1.
- rst_n pulled low on the 2nd BUSY cycle -> mc_busy = 0 and stall_ex = 0 without waiting for a clock edge. After release, a new ex_mc_start gives a full 4-cycle stall.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls plus one MC_LAT = 4 op -> stall_cycles = 7. Two taken branches -> flush_events = 2.
